mem_io_responder: RTL and testbench

- Responder end of the CPU byte-wide memory bus: answers the core's address, write-data and read/write-strobe outputs, and drives the read-data bus and ready.
- Contains a 128 KB byte RAM and the memory-mapped I/O block at 0x30000/0x30004: console input, console output, cycle counter and program stop.
- Sits between the CPU top and the UART/host link.
- Read latency is 2 cycles; writes complete in 1 cycle.

---
 rtl/mem_io_responder.sv | 208 ++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the CPU byte-wide memory bus.
// Holds a byte RAM plus a small I/O block with console input and output FIFOs,
// a free-running cycle counter with a snapshot register, and a program-stop latch.
// Reads return data two cycles after acceptance. Writes complete at the accepting edge.
module mem_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int RX_DEPTH   = 8,
   parameter int TX_DEPTH   = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_wdata,
   output logic [7:0]  mem_rdata,
   output logic        cpu_rdy,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        halted
);

   localparam int RX_AW     = $clog2(RX_DEPTH);
   localparam int TX_AW     = $clog2(TX_DEPTH);
   localparam int RAM_BYTES = 1 << ADDR_WIDTH;
   localparam logic [RX_AW:0] RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};
   localparam logic [TX_AW:0] TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};

   // Storage arrays (never reset; RAM contents survive reset)
   logic [7:0] ram_mem [RAM_BYTES];
   logic [7:0] rx_mem  [RX_DEPTH];
   logic [7:0] tx_mem  [TX_DEPTH];

   // Registered state
   logic [31:0]           cycle_cnt_q, cycle_cnt_d;
   logic [31:0]           snap_q,      snap_d;
   logic                  rd_valid_q,  rd_valid_d;
   logic                  rd_is_ram_q, rd_is_ram_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
   logic [7:0]            rd_byte_q,   rd_byte_d;
   logic [7:0]            mem_rdata_q, mem_rdata_d;
   logic                  halted_q,    halted_d;
   logic [RX_AW:0]        rx_wptr_q,   rx_wptr_d;
   logic [RX_AW:0]        rx_rptr_q,   rx_rptr_d;
   logic [TX_AW:0]        tx_wptr_q,   tx_wptr_d;
   logic [TX_AW:0]        tx_rptr_q,   tx_rptr_d;

   // Combinational decode and handshake terms
   logic       is_io_s;
   logic [2:0] io_reg_s;
   logic       rx_rd_s;
   logic       tx_wr_s;
   logic       stop_wr_s;
   logic       cnt_rd_s;
   logic       rx_empty_s;
   logic       rx_full_s;
   logic       tx_empty_s;
   logic       tx_full_s;
   logic       stall_s;
   logic       accept_s;
   logic       ram_we_s;
   logic       rx_push_s;
   logic       rx_pop_s;
   logic       tx_push_s;
   logic       tx_pop_s;
   logic [7:0] tx_push_byte_s;
   logic       unused_mem_a_s;

   // Address bits above the I/O select bit are ignored by design
   assign unused_mem_a_s = ^mem_a[31:18];

   // Decode the bus request, FIFO status and the stall condition
   always_comb begin
      is_io_s   = mem_a[17];
      io_reg_s  = mem_a[2:0];
      rx_rd_s   = is_io_s && (io_reg_s == 3'd0) && !mem_wr;
      tx_wr_s   = is_io_s && (io_reg_s == 3'd0) && mem_wr && (mem_wdata != 8'h00);
      stop_wr_s = is_io_s && (io_reg_s == 3'd4) && mem_wr;
      cnt_rd_s  = is_io_s && io_reg_s[2] && !mem_wr;

      rx_empty_s = (rx_wptr_q == rx_rptr_q);
      rx_full_s  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                   (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
      tx_empty_s = (tx_wptr_q == tx_rptr_q);
      tx_full_s  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                   (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);

      // TX full is judged on pre-pop occupancy so a same-cycle pop never unblocks a push
      stall_s  = halted_q || (rx_rd_s && rx_empty_s) || ((tx_wr_s || stop_wr_s) && tx_full_s);
      accept_s = !stall_s && !rst_in;

      ram_we_s       = accept_s && mem_wr && !is_io_s;
      rx_push_s      = rx_valid && !rx_full_s;
      rx_pop_s       = accept_s && rx_rd_s;
      tx_push_s      = accept_s && (tx_wr_s || stop_wr_s);
      tx_pop_s       = !tx_empty_s && tx_ready;
      tx_push_byte_s = stop_wr_s ? 8'h00 : mem_wdata;
   end

   // Next-state logic for counter, snapshot, read pipeline, FIFO pointers and halt
   always_comb begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      snap_d      = snap_q;
      rd_valid_d  = 1'b0;
      rd_is_ram_d = rd_is_ram_q;
      rd_addr_d   = rd_addr_q;
      rd_byte_d   = rd_byte_q;
      mem_rdata_d = mem_rdata_q;
      halted_d    = halted_q || (accept_s && stop_wr_s);
      rx_wptr_d   = rx_push_s ? (rx_wptr_q + RX_PTR_ONE) : rx_wptr_q;
      rx_rptr_d   = rx_pop_s  ? (rx_rptr_q + RX_PTR_ONE) : rx_rptr_q;
      tx_wptr_d   = tx_push_s ? (tx_wptr_q + TX_PTR_ONE) : tx_wptr_q;
      tx_rptr_d   = tx_pop_s  ? (tx_rptr_q + TX_PTR_ONE) : tx_rptr_q;

      // Stage 1: capture the accepted read; I/O bytes are resolved now so pops and
      // snapshots take effect at acceptance
      if (accept_s && !mem_wr) begin
         rd_valid_d  = 1'b1;
         rd_is_ram_d = !is_io_s;
         rd_addr_d   = mem_a[ADDR_WIDTH-1:0];
         if (rx_rd_s) begin
            rd_byte_d = rx_mem[rx_rptr_q[RX_AW-1:0]];
         end else if (cnt_rd_s) begin
            case (mem_a[1:0])
               2'd0: begin
                  rd_byte_d = cycle_cnt_q[7:0];
                  snap_d    = cycle_cnt_q;
               end
               2'd1:    rd_byte_d = snap_q[15:8];
               2'd2:    rd_byte_d = snap_q[23:16];
               2'd3:    rd_byte_d = snap_q[31:24];
               default: rd_byte_d = 8'h00;
            endcase
         end else begin
            rd_byte_d = 8'h00;
         end
      end else begin
         rd_valid_d = 1'b0;
      end

      // Stage 2: RAM is read one edge after acceptance, so a write accepted in
      // the following cycle lands on the same edge and is not seen
      if (rd_valid_q) begin
         mem_rdata_d = rd_is_ram_q ? ram_mem[rd_addr_q] : rd_byte_q;
      end else begin
         mem_rdata_d = mem_rdata_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cycle_cnt_q <= 32'd0;
         snap_q      <= 32'd0;
         rd_valid_q  <= 1'b0;
         rd_is_ram_q <= 1'b0;
         rd_addr_q   <= {ADDR_WIDTH{1'b0}};
         rd_byte_q   <= 8'h00;
         mem_rdata_q <= 8'h00;
         halted_q    <= 1'b0;
         rx_wptr_q   <= {(RX_AW+1){1'b0}};
         rx_rptr_q   <= {(RX_AW+1){1'b0}};
         tx_wptr_q   <= {(TX_AW+1){1'b0}};
         tx_rptr_q   <= {(TX_AW+1){1'b0}};
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         snap_q      <= snap_d;
         rd_valid_q  <= rd_valid_d;
         rd_is_ram_q <= rd_is_ram_d;
         rd_addr_q   <= rd_addr_d;
         rd_byte_q   <= rd_byte_d;
         mem_rdata_q <= mem_rdata_d;
         halted_q    <= halted_d;
         rx_wptr_q   <= rx_wptr_d;
         rx_rptr_q   <= rx_rptr_d;
         tx_wptr_q   <= tx_wptr_d;
         tx_rptr_q   <= tx_rptr_d;
      end
   end

   // RAM byte write at the accepting edge
   always_ff @(posedge clk_in) begin
      if (ram_we_s) begin
         ram_mem[mem_a[ADDR_WIDTH-1:0]] <= mem_wdata;
      end
   end

   // FIFO data storage writes
   always_ff @(posedge clk_in) begin
      if (rx_push_s) begin
         rx_mem[rx_wptr_q[RX_AW-1:0]] <= rx_data;
      end
      if (tx_push_s) begin
         tx_mem[tx_wptr_q[TX_AW-1:0]] <= tx_push_byte_s;
      end
   end

   assign mem_rdata = mem_rdata_q;
   assign cpu_rdy   = !stall_s;
   assign rx_ready  = !rx_full_s;
   assign tx_valid  = !tx_empty_s;
   assign tx_data   = tx_empty_s ? 8'h00 : tx_mem[tx_rptr_q[TX_AW-1:0]];
   assign halted    = halted_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed bus scenarios followed by
// randomized RAM/counter traffic checked against a behavioural model.
module tb_mem_io_responder;

   localparam logic [31:0] IDLE_A = 32'h0003_0002;
   localparam logic [31:0] IO_CON = 32'h0003_0000;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [31:0] mem_a = 32'h0003_0002;
   logic        mem_wr = 1'b1;
   logic [7:0]  mem_wdata = 8'h00;
   logic [7:0]  mem_rdata;
   logic        cpu_rdy;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        halted;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cnt_m = 32'd0;
   logic [7:0]  tx_seen [$];
   logic [7:0]  tx_exp  [$];
   logic [7:0]  rxq     [$];
   logic [7:0]  mem_m   [int];
   logic [31:0] snap_v;
   logic [7:0]  d_v, cur_d, p1_d, p2_d, exp_rd;
   logic        cur_v, p1_v, p2_v, have_rd;
   int          op, k;

   always #5 clk_in = ~clk_in;

   mem_io_responder #(.ADDR_WIDTH(17), .RX_DEPTH(8), .TX_DEPTH(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_rdy(cpu_rdy),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .halted(halted)
   );

   // Reference cycle count: zero at a reset edge, +1 on every other edge
   always @(posedge clk_in) begin
      if (rst_in) cnt_m <= 32'd0;
      else        cnt_m <= cnt_m + 32'd1;
   end

   // Record every byte handed to the consumer
   always @(negedge clk_in) begin
      if (!rst_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);
   end

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected summary");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_tx(input string tag);
      chk({tag, "_len"}, 32'(tx_seen.size()), 32'(tx_exp.size()));
      for (int i = 0; i < tx_exp.size(); i++) begin
         if (i < tx_seen.size()) chk($sformatf("%s_%0d", tag, i), 32'(tx_seen[i]), 32'(tx_exp[i]));
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] wd);
      mem_a = a; mem_wr = wr; mem_wdata = wd;
   endtask

   task automatic idle();
      drive(IDLE_A, 1'b1, 8'h00);
   endtask

   task automatic mid();
      @(negedge clk_in);
   endtask

   task automatic tick();
      @(posedge clk_in); #1;
   endtask

   function automatic logic [31:0] rand_addr(input int idx);
      return (idx < 16) ? (32'h0000_0100 + 32'(idx)) : (32'h0001_F000 + 32'(idx - 16));
   endfunction

   initial begin
      // ---------------- reset ----------------
      idle();
      repeat (3) @(posedge clk_in);
      #1; rst_in = 1'b0;
      mid();
      chk("rst_rdata", 32'(mem_rdata), 32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_rx_ready", 32'(rx_ready), 32'h1);
      chk("rst_cpu_rdy", 32'(cpu_rdy), 32'h1);
      tick();

      // ---------------- RAM write/read ----------------
      drive(32'h10, 1'b1, 8'hA5); mid(); chk("ram_wr_rdy", 32'(cpu_rdy), 32'h1); tick();
      drive(32'h10, 1'b0, 8'h00); tick();
      drive(32'h11, 1'b1, 8'h3C); mid(); chk("ram_rd_not_lat1", 32'(mem_rdata), 32'h0); tick();
      drive(32'h10, 1'b0, 8'h00); mid(); chk("ram_rd_lat2", 32'(mem_rdata), 32'hA5); tick();
      drive(32'h11, 1'b0, 8'h00); tick();
      idle(); mid(); chk("b2b_first", 32'(mem_rdata), 32'hA5); tick();
      mid(); chk("b2b_second", 32'(mem_rdata), 32'h3C); tick();
      mid(); chk("rdata_hold", 32'(mem_rdata), 32'h3C); tick();
      drive(32'h10, 1'b0, 8'h00); tick();
      drive(32'h10, 1'b1, 8'h5A); tick();
      idle(); mid(); chk("rd_before_later_wr", 32'(mem_rdata), 32'hA5); tick();
      drive(32'h10, 1'b0, 8'h00); tick();
      idle(); tick();
      mid(); chk("ram_rewritten", 32'(mem_rdata), 32'h5A); tick();
      drive(32'h10, 1'b1, 8'hA5); tick();

      // ---------------- console output ----------------
      tx_ready = 1'b1; tx_seen.delete(); tx_exp.delete();
      drive(IO_CON, 1'b1, 8'h41); mid(); chk("tx_w41_rdy", 32'(cpu_rdy), 32'h1); tick();
      drive(IO_CON, 1'b1, 8'h00); mid(); chk("tx_w00_rdy", 32'(cpu_rdy), 32'h1); tick();
      drive(IO_CON, 1'b1, 8'h42); mid(); chk("tx_w42_rdy", 32'(cpu_rdy), 32'h1); tick();
      idle(); repeat (4) tick();
      tx_exp.push_back(8'h41); tx_exp.push_back(8'h42);
      chk_tx("tx_stream");

      tx_ready = 1'b0; tx_seen.delete(); tx_exp.delete();
      for (int i = 0; i < 8; i++) begin
         drive(IO_CON, 1'b1, 8'h50 + 8'(i));
         tx_exp.push_back(8'h50 + 8'(i));
         mid(); chk("tx_fill_rdy", 32'(cpu_rdy), 32'h1); tick();
      end
      drive(IO_CON, 1'b1, 8'h58);
      mid(); chk("tx_full_stall", 32'(cpu_rdy), 32'h0); chk("tx_head_stable", 32'(tx_data), 32'h50); tick();
      mid(); chk("tx_full_stall_hold", 32'(cpu_rdy), 32'h0); chk("tx_head_stable2", 32'(tx_data), 32'h50); tick();
      tx_ready = 1'b1; mid(); chk("tx_pop_full_still_stall", 32'(cpu_rdy), 32'h0); tick();
      tx_ready = 1'b0; mid(); chk("tx_resume", 32'(cpu_rdy), 32'h1); tick();
      tx_exp.push_back(8'h58);
      idle(); tx_ready = 1'b1; repeat (12) tick();
      chk_tx("tx_stream_full");

      // ---------------- console input ----------------
      drive(IO_CON, 1'b0, 8'h00); mid(); chk("rx_empty_stall", 32'(cpu_rdy), 32'h0); tick();
      rx_valid = 1'b1; rx_data = 8'h7E; mid(); chk("rx_empty_stall2", 32'(cpu_rdy), 32'h0); tick();
      rx_valid = 1'b0; mid(); chk("rx_avail_rdy", 32'(cpu_rdy), 32'h1); tick();
      idle(); tick();
      mid(); chk("rx_byte", 32'(mem_rdata), 32'h7E); tick();

      rxq.delete();
      for (int i = 0; i < 8; i++) begin
         rx_valid = 1'b1; rx_data = 8'($urandom); rxq.push_back(rx_data);
         mid(); chk("rx_ready_fill", 32'(rx_ready), 32'h1); tick();
      end
      rx_valid = 1'b1; rx_data = 8'hEE; mid(); chk("rx_full", 32'(rx_ready), 32'h0); tick();
      rx_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) drive(IO_CON, 1'b0, 8'h00);
         else       idle();
         mid();
         if (i < 8)  chk("rx_drain_rdy", 32'(cpu_rdy), 32'h1);
         if (i >= 2) chk($sformatf("rx_order_%0d", i - 2), 32'(mem_rdata), 32'(rxq[i-2]));
         tick();
      end
      drive(IO_CON, 1'b0, 8'h00); mid(); chk("rx_drained_stall", 32'(cpu_rdy), 32'h0); tick();
      idle();

      // ---------------- cycle counter ----------------
      while (cnt_m < 32'd300) tick();
      drive(32'h0003_0004, 1'b0, 8'h00); snap_v = cnt_m; tick();
      drive(32'h0003_0005, 1'b0, 8'h00); tick();
      idle(); mid(); chk("cnt_b0", 32'(mem_rdata), 32'(snap_v[7:0])); tick();
      mid(); chk("cnt_b1", 32'(mem_rdata), 32'(snap_v[15:8])); tick();
      repeat (300) tick();
      drive(32'h0003_0005, 1'b0, 8'h00); tick();
      drive(32'h0003_0007, 1'b0, 8'h00); tick();
      drive(32'h0003_0006, 1'b0, 8'h00); mid(); chk("cnt_b1_again", 32'(mem_rdata), 32'(snap_v[15:8])); tick();
      drive(32'h0003_0003, 1'b0, 8'h00); mid(); chk("cnt_b3", 32'(mem_rdata), 32'(snap_v[31:24])); tick();
      drive(32'h0003_0004, 1'b0, 8'h00); snap_v = cnt_m; mid(); chk("cnt_b2", 32'(mem_rdata), 32'(snap_v[23:16] & 8'h00)); tick();
      drive(32'h0003_0005, 1'b0, 8'h00); mid(); chk("io_unused_rd", 32'(mem_rdata), 32'h0); tick();
      idle(); mid(); chk("cnt_new_b0", 32'(mem_rdata), 32'(snap_v[7:0])); tick();
      mid(); chk("cnt_new_b1", 32'(mem_rdata), 32'(snap_v[15:8])); tick();

      // ---------------- program stop ----------------
      tx_ready = 1'b1; tx_seen.delete();
      drive(32'h20, 1'b1, 8'h11); tick();
      drive(32'h0003_0004, 1'b1, 8'h99); mid(); chk("stop_rdy", 32'(cpu_rdy), 32'h1); tick();
      drive(32'h20, 1'b1, 8'hEE);
      mid();
      chk("halted_set", 32'(halted), 32'h1);
      chk("halt_stall", 32'(cpu_rdy), 32'h0);
      chk("stop_tx_valid", 32'(tx_valid), 32'h1);
      chk("stop_tx_byte", 32'(tx_data), 32'h0);
      tick();
      mid(); chk("halt_hold", 32'(cpu_rdy), 32'h0); chk("halt_hold_flag", 32'(halted), 32'h1); tick();
      tx_exp.delete(); tx_exp.push_back(8'h00);
      chk_tx("stop_stream");
      rst_in = 1'b1; idle(); tick();
      rst_in = 1'b0;
      mid();
      chk("unhalt", 32'(halted), 32'h0);
      chk("unhalt_rdy", 32'(cpu_rdy), 32'h1);
      chk("unhalt_tx_valid", 32'(tx_valid), 32'h0);
      tick();
      drive(32'h20, 1'b0, 8'h00); tick();
      drive(32'h0003_0005, 1'b0, 8'h00); tick();
      idle(); mid(); chk("halt_blocked_write", 32'(mem_rdata), 32'h11); tick();
      mid(); chk("snap_reset", 32'(mem_rdata), 32'h0); tick();

      // ---------------- reset mid-read ----------------
      tx_ready = 1'b0;
      drive(IO_CON, 1'b1, 8'h61); tick();
      drive(IO_CON, 1'b1, 8'h62); tick();
      drive(32'h10, 1'b1, 8'h00 | 8'h00); drive(32'h30, 1'b1, 8'h77); tick();
      drive(32'h30, 1'b0, 8'h00); tick();
      idle(); tick();
      mid(); chk("pre_rst_rdata", 32'(mem_rdata), 32'h77); tick();
      drive(32'h10, 1'b0, 8'h00); tick();
      rst_in = 1'b1; idle(); tick();
      rst_in = 1'b0;
      mid(); chk("rst_mid_rdata", 32'(mem_rdata), 32'h0); chk("rst_tx_lost", 32'(tx_valid), 32'h0); tick();
      mid(); chk("rst_mid_rdata_stays", 32'(mem_rdata), 32'h0); tick();
      drive(32'h10, 1'b0, 8'h00); tick();
      idle(); tick();
      mid(); chk("ram_survives_reset", 32'(mem_rdata), 32'hA5); tick();

      // ---------------- randomized RAM / counter traffic ----------------
      for (int i = 0; i < 32; i++) begin
         d_v = 8'($urandom);
         drive(rand_addr(i), 1'b1, d_v);
         mem_m[i] = d_v;
         tick();
      end
      p1_v = 1'b0; p2_v = 1'b0; p1_d = 8'h00; p2_d = 8'h00; have_rd = 1'b0; exp_rd = 8'h00;
      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 9);
         k  = $urandom_range(0, 31);
         d_v = 8'($urandom);
         cur_v = 1'b0; cur_d = 8'h00;
         if (op < 4) begin
            drive(rand_addr(k), 1'b1, d_v);
         end else if (op < 9) begin
            drive(rand_addr(k), 1'b0, 8'h00);
            cur_v = 1'b1; cur_d = mem_m[k];
         end else begin
            drive(32'h0003_0004, 1'b0, 8'h00);
            cur_v = 1'b1; cur_d = cnt_m[7:0];
         end
         mid();
         if (p2_v) begin
            exp_rd = p2_d; have_rd = 1'b1;
         end
         if (have_rd) chk("rand_rdata", 32'(mem_rdata), 32'(exp_rd));
         chk("rand_rdy", 32'(cpu_rdy), 32'h1);
         if (op < 4) mem_m[k] = d_v;
         p2_v = p1_v; p2_d = p1_d; p1_v = cur_v; p1_d = cur_d;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
